// File: rtl/datapath_sequencer.sv
// Expands one macro-instruction per valid/ready handshake into a sequence of
// datapath control words {DA,SA,SB,FS,regW,ramW,selALU,selK} plus constant K.
module datapath_sequencer #(
    parameter logic [4:0] FS_ADD  = 5'b01000,
    parameter logic [4:0] FS_SUB  = 5'b01001,
    parameter logic [4:0] SCRATCH = 5'd31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [63:0] imm,
    output logic [23:0] controlWord,
    output logic [63:0] K,
    input  logic [3:0]  status,
    output logic [3:0]  flags,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_LDR  = 3'd3;
    localparam logic [2:0] OP_STR  = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_MULI = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] cw_q, cw_d;
    logic [63:0] k_q, k_d;
    logic [3:0]  flags_q, flags_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [1:0]  ph;

    // ph selects the word within a sequence: 0 first, 1 second/MULI add, 2 SWAP third.
    function automatic logic [87:0] build_word(input logic [2:0] op, input logic [4:0] d,
                                               input logic [4:0] n, input logic [4:0] m,
                                               input logic [63:0] im, input logic [1:0] p);
        logic [23:0] cw;
        logic [63:0] k;
        cw = '0;
        k  = '0;
        case (op)
            OP_ADD:  cw = {d, n, m, FS_ADD, 4'b1010};
            OP_ADDI: begin cw = {d, n, 5'd0, FS_ADD, 4'b1011}; k = im; end
            OP_SUB:  cw = {d, n, m, FS_SUB, 4'b1010};
            OP_LDR:  begin cw = {d, n, 5'd0, FS_ADD, 4'b1001}; k = im; end
            OP_STR:  begin cw = {5'd0, n, m, FS_ADD, 4'b0111}; k = im; end
            OP_SWAP: begin
                case (p)
                    2'd0:    cw = {SCRATCH, n, 5'd0, FS_ADD, 4'b1011};
                    2'd1:    cw = {n, m, 5'd0, FS_ADD, 4'b1011};
                    default: cw = {m, SCRATCH, 5'd0, FS_ADD, 4'b1011};
                endcase
            end
            // First MULI word clears rd via rd-rd; the rest accumulate rn.
            OP_MULI: cw = (p == 2'd0) ? {d, d, d, FS_SUB, 4'b1010} : {d, d, n, FS_ADD, 4'b1010};
            default: cw = '0;
        endcase
        return {cw, k};
    endfunction

    assign ph = (op_q == OP_SWAP && cnt_q == 5'd1) ? 2'd2 : 2'd1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        cnt_d   = cnt_q;
        cw_d    = '0;
        k_d     = '0;
        flags_d = flags_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = opcode;
                    rd_d    = rd;
                    rn_d    = rn;
                    rm_d    = rm;
                    cnt_d   = (opcode == OP_SWAP) ? 5'd2 :
                              (opcode == OP_MULI) ? imm[4:0] : 5'd0;
                    {cw_d, k_d} = build_word(opcode, rd, rn, rm, imm, 2'd0);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (op_q == OP_SUB) flags_d = status;
                if (cnt_q == 5'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    {cw_d, k_d} = build_word(op_q, rd_q, rn_q, rm_q, 64'd0, ph);
                    cnt_d  = cnt_q - 5'd1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            cnt_q   <= '0;
            cw_q    <= '0;
            k_q     <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            cnt_q   <= cnt_d;
            cw_q    <= cw_d;
            k_q     <= k_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign controlWord = cw_q;
    assign K           = k_q;
    assign flags       = flags_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench: a register-file/ALU/RAM model is driven by the sequencer, and a
// scoreboard queue of expected control words is checked word by word.
module tb_datapath_sequencer;

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [2:0] OP_ADD = 3'd0, OP_ADDI = 3'd1, OP_SUB = 3'd2, OP_LDR = 3'd3;
    localparam logic [2:0] OP_STR = 3'd4, OP_SWAP = 3'd5, OP_MULI = 3'd6, OP_NOP = 3'd7;

    logic        clock, reset, instr_valid, instr_ready, busy, done;
    logic [2:0]  opcode;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm, K;
    logic [23:0] controlWord;
    logic [3:0]  status, flags;

    datapath_sequencer dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .controlWord(controlWord),
        .K(K), .status(status), .flags(flags), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath model
    logic [63:0] R [32];
    logic [63:0] ram [256];
    logic [4:0]  f_da, f_sa, f_sb, f_fs;
    logic        f_rw, f_mw, f_selalu, f_selk;
    logic [63:0] a_bus, b_bus, f_bus;

    assign {f_da, f_sa, f_sb, f_fs, f_rw, f_mw, f_selalu, f_selk} = controlWord;
    assign a_bus  = R[f_sa];
    assign b_bus  = f_selk ? K : R[f_sb];
    assign f_bus  = (f_fs == FS_SUB) ? a_bus - b_bus : a_bus + b_bus;
    assign status = {2'b00, f_bus[63], f_bus == 64'd0};

    always @(posedge clock) begin
        if (f_rw && f_da != 5'd0) R[f_da] <= f_selalu ? f_bus : ram[f_bus[7:0]];
        if (f_mw) ram[f_bus[7:0]] <= R[f_sb];
    end

    typedef struct {
        logic [23:0] cw;
        logic [63:0] k;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   words_seen = 0;
    bit   prev_last = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] cwf(input logic [4:0] da, input logic [4:0] sa,
                                        input logic [4:0] sbi, input logic [4:0] fs,
                                        input logic rw, input logic mw, input logic al,
                                        input logic sk);
        return {da, sa, sbi, fs, rw, mw, al, sk};
    endfunction

    task automatic push(input logic [23:0] cw, input logic [63:0] k);
        exp_t e;
        e.cw = cw;
        e.k = k;
        e.last = 0;
        sb.push_back(e);
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [4:0] d, input logic [4:0] n,
                            input logic [4:0] m, input logic [63:0] im);
        case (op)
            OP_ADD:  push(cwf(d, n, m, FS_ADD, 1, 0, 1, 0), 0);
            OP_ADDI: push(cwf(d, n, 0, FS_ADD, 1, 0, 1, 1), im);
            OP_SUB:  push(cwf(d, n, m, FS_SUB, 1, 0, 1, 0), 0);
            OP_LDR:  push(cwf(d, n, 0, FS_ADD, 1, 0, 0, 1), im);
            OP_STR:  push(cwf(0, n, m, FS_ADD, 0, 1, 1, 1), im);
            OP_SWAP: begin
                push(cwf(5'd31, n, 0, FS_ADD, 1, 0, 1, 1), 0);
                push(cwf(n, m, 0, FS_ADD, 1, 0, 1, 1), 0);
                push(cwf(m, 5'd31, 0, FS_ADD, 1, 0, 1, 1), 0);
            end
            OP_MULI: begin
                push(cwf(d, d, d, FS_SUB, 1, 0, 1, 0), 0);
                for (int i = 0; i < int'(im[4:0]); i++) push(cwf(d, d, n, FS_ADD, 1, 0, 1, 0), 0);
            end
            default: push(24'h0, 0);
        endcase
        sb[sb.size()-1].last = 1;
    endtask

    // Scoreboard monitor: one expected entry per busy cycle; done follows the last word.
    always @(negedge clock) begin
        if (!reset) begin
            prev_last = 0;
        end else begin
            chk("done", done, prev_last);
            chk("ready_vs_busy", instr_ready, !busy);
            if (busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", controlWord, 24'hffffff);
                    prev_last = 0;
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("controlWord", controlWord, e.cw);
                    if (e.cw[0]) chk("K", K, e.k);
                    prev_last = e.last;
                    words_seen++;
                end
            end else begin
                chk("idle_word", controlWord, 24'h0);
                prev_last = 0;
            end
        end
    end

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic issue(input logic [2:0] op, input logic [4:0] d, input logic [4:0] n,
                         input logic [4:0] m, input logic [63:0] im, input bit hold);
        bit acc, got;
        got = 0;
        push_exp(op, d, n, m, im);
        opcode = op; rd = d; rn = n; rm = m; imm = im;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            acc = instr_ready;
            @(posedge clock);
            got = acc;
            @(negedge clock);
        end
        if (!got) chk("accept_timeout", got, 1);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (!busy && sb.size() == 0) ok = 1;
            else @(negedge clock);
        end
        if (!ok) chk("idle_timeout", ok, 1);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) R[i] = 64'd0;
        for (int i = 0; i < 256; i++) ram[i] = 64'd0;
        reset = 1'b0; instr_valid = 1'b0; opcode = '0; rd = '0; rn = '0; rm = '0; imm = '0;
        repeat (3) @(negedge clock);
        chk("rst_cw", controlWord, 24'h0);
        chk("rst_K", K, 64'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", flags, 4'h0);
        chk("rst_ready", instr_ready, 1);
        reset = 1'b1;
        @(negedge clock);

        // Abort MULI n=10 during its fourth word
        issue(OP_MULI, 5'd7, 5'd6, 5'd0, 64'd10, 0);
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        chk("abort_cw", controlWord, 24'h0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", instr_ready, 1);
        chk("abort_done", done, 0);
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);

        issue(OP_ADDI, 5'd3, 5'd0, 5'd0, 64'd5, 0);
        wait_idle();
        chk("R3", R[3], 64'd5);
        issue(OP_ADDI, 5'd1, 5'd0, 5'd0, 64'd7, 0);
        wait_idle();
        issue(OP_ADDI, 5'd2, 5'd0, 5'd0, 64'd9, 0);
        wait_idle();
        issue(OP_ADDI, 5'd6, 5'd0, 5'd0, 64'd3, 0);
        wait_idle();

        issue(OP_SUB, 5'd4, 5'd2, 5'd2, 64'd0, 0);
        wait_idle();
        chk("flags_sub", flags, 4'b0001);
        chk("R4", R[4], 64'd0);
        issue(OP_ADD, 5'd8, 5'd1, 5'd2, 64'd0, 0);
        wait_idle();
        chk("flags_hold_add", flags, 4'b0001);
        chk("R8", R[8], 64'd16);

        words_seen = 0;
        issue(OP_SWAP, 5'd0, 5'd1, 5'd2, 64'd0, 0);
        wait_idle();
        chk("swap_words", words_seen, 3);
        chk("R1", R[1], 64'd9);
        chk("R2", R[2], 64'd7);
        chk("R31", R[31], 64'd7);

        words_seen = 0;
        issue(OP_MULI, 5'd5, 5'd6, 5'd0, 64'd4, 0);
        wait_idle();
        chk("muli4_words", words_seen, 5);
        chk("R5_12", R[5], 64'd12);
        chk("flags_hold_muli", flags, 4'b0001);
        words_seen = 0;
        issue(OP_MULI, 5'd5, 5'd6, 5'd0, 64'd0, 0);
        wait_idle();
        chk("muli0_words", words_seen, 1);
        chk("R5_0", R[5], 64'd0);

        words_seen = 0;
        issue(OP_NOP, 5'd0, 5'd0, 5'd0, 64'd0, 0);
        wait_idle();
        chk("nop_words", words_seen, 1);

        issue(OP_STR, 5'd0, 5'd0, 5'd1, 64'd16, 1);
        issue(OP_LDR, 5'd10, 5'd0, 5'd0, 64'd16, 0);
        wait_idle();
        chk("ram16", ram[16], 64'd9);
        chk("R10", R[10], 64'd9);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
